i2c_target_mem: RTL and testbench

- Simulation and FPGA-usable I2C target (responder) with a small byte-addressed register memory.
- Attaches to a system I2C bus so controller-side software can be exercised against a real responder: addressing, ACK/NACK, pointer writes, sequential reads and writes.
- Oversamples SCL/SDA on the system clock. Drives SDA open-drain only: low or released.
- Never stretches SCL.

---
 rtl/i2c_target_mem.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_target_mem.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_mem.sv
// I2C target with a small byte-addressed register memory.
// SCL/SDA are oversampled on clk_i; SDA is driven open-drain (low or released)
// and SCL is never stretched. Writes set the pointer, then fill memory; reads
// stream bytes from the pointer, which auto-increments and wraps.
module i2c_target_mem #(
   parameter logic [6:0] TargetAddr = 7'h50,
   parameter int         MemDepth   = 16,
   parameter int         SyncStages = 2,
   localparam int        PtrW       = $clog2(MemDepth)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            scl_i,
   input  logic            sda_i,
   output logic            sda_oe_o,
   output logic            busy_o,
   output logic [PtrW-1:0] ptr_o,
   output logic            wr_strobe_o
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
   } state_t;

   logic [SyncStages-1:0] scl_sync, sda_sync;
   logic                  scl_s, sda_s, scl_prev, sda_prev;
   logic                  start_ev, stop_ev, rise_ev, fall_ev;

   state_t                state, state_next;
   logic [7:0]            shifter, shifter_next;
   logic [3:0]            bit_cnt, bit_cnt_next;
   logic [PtrW-1:0]       ptr, ptr_next, ptr_inc;
   logic                  sda_oe, sda_oe_next;
   logic                  busy, busy_next;
   logic                  wr_strobe, wr_strobe_next;
   logic                  mem_we;
   logic                  addr_match;
   logic                  byte_done;
   logic [7:0]            mem_rd, mem_rd_inc;
   logic [7:0]            mem [MemDepth];

   assign scl_s = scl_sync[SyncStages-1];
   assign sda_s = sda_sync[SyncStages-1];

   // START/STOP need SCL high in both this and the previous cycle so an SDA
   // edge coinciding with an SCL edge is never mistaken for a bus condition.
   assign start_ev = scl_s & scl_prev & sda_prev & ~sda_s;
   assign stop_ev  = scl_s & scl_prev & ~sda_prev & sda_s;
   assign rise_ev  = scl_s & ~scl_prev;
   assign fall_ev  = ~scl_s & scl_prev;

   assign addr_match = (shifter[7:1] == TargetAddr);
   assign byte_done  = fall_ev && (bit_cnt == 4'd8);
   assign ptr_inc    = ptr + PtrW'(1);
   assign mem_rd     = mem[ptr];
   assign mem_rd_inc = mem[ptr_inc];

   // Bring the bus lines into the clk_i domain and keep a one-cycle history.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SyncStages-2:0], scl_i};
         sda_sync <= {sda_sync[SyncStages-2:0], sda_i};
         scl_prev <= scl_s;
         sda_prev <= sda_s;
      end
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; bus conditions override all bit-level progress.
   always_comb begin
      state_next = state;
      if (start_ev) begin
         state_next = ADDR;
      end else if (stop_ev) begin
         state_next = IDLE;
      end else begin
         case (state)
            ADDR:     if (byte_done) state_next = addr_match ? ADDR_ACK : IGNORE;
            ADDR_ACK: if (fall_ev)   state_next = shifter[0] ? RD_DATA : WR_PTR;
            WR_PTR:   if (byte_done) state_next = WR_ACK;
            WR_DATA:  if (byte_done) state_next = WR_ACK;
            WR_ACK:   if (fall_ev)   state_next = WR_DATA;
            RD_DATA:  if (byte_done) state_next = RD_ACK;
            RD_ACK:   if (rise_ev)   state_next = sda_s ? IGNORE : RD_DATA;
            default:  state_next = state;
         endcase
      end
   end

   // Datapath and output decisions: shifting, pointer, memory write, SDA drive.
   always_comb begin
      shifter_next   = shifter;
      bit_cnt_next   = bit_cnt;
      ptr_next       = ptr;
      sda_oe_next    = sda_oe;
      busy_next      = busy;
      wr_strobe_next = 1'b0;
      mem_we         = 1'b0;
      if (start_ev) begin
         // A half-shifted byte is simply dropped; busy holds until the new
         // address is judged.
         bit_cnt_next = '0;
         sda_oe_next  = 1'b0;
      end else if (stop_ev) begin
         bit_cnt_next = '0;
         sda_oe_next  = 1'b0;
         busy_next    = 1'b0;
      end else begin
         case (state)
            ADDR, WR_PTR, WR_DATA: begin
               if (rise_ev && (bit_cnt < 4'd8)) begin
                  shifter_next = {shifter[6:0], sda_s};
                  bit_cnt_next = bit_cnt + 4'd1;
               end else if (byte_done) begin
                  bit_cnt_next = '0;
                  if (state == ADDR) begin
                     busy_next   = addr_match;
                     sda_oe_next = addr_match;
                  end else if (state == WR_PTR) begin
                     ptr_next    = shifter[PtrW-1:0];
                     sda_oe_next = 1'b1;
                  end else begin
                     mem_we         = 1'b1;
                     wr_strobe_next = 1'b1;
                     ptr_next       = ptr_inc;
                     sda_oe_next    = 1'b1;
                  end
               end
            end
            ADDR_ACK: begin
               if (fall_ev) begin
                  if (shifter[0]) begin
                     // The fall ending the ACK also launches the first read bit.
                     shifter_next = {mem_rd[6:0], 1'b0};
                     sda_oe_next  = ~mem_rd[7];
                     bit_cnt_next = 4'd1;
                  end else begin
                     sda_oe_next  = 1'b0;
                     bit_cnt_next = '0;
                  end
               end
            end
            WR_ACK: begin
               if (fall_ev) begin
                  sda_oe_next  = 1'b0;
                  bit_cnt_next = '0;
               end
            end
            RD_DATA: begin
               if (fall_ev) begin
                  if (bit_cnt == 4'd8) begin
                     sda_oe_next = 1'b0;
                  end else begin
                     sda_oe_next  = ~shifter[7];
                     shifter_next = {shifter[6:0], 1'b0};
                     bit_cnt_next = bit_cnt + 4'd1;
                  end
               end
            end
            RD_ACK: begin
               if (rise_ev) begin
                  // Pointer moves past the byte just read whether ACKed or not.
                  ptr_next = ptr_inc;
                  if (!sda_s) begin
                     shifter_next = mem_rd_inc;
                     bit_cnt_next = '0;
                  end
               end
            end
            default: begin
               sda_oe_next = 1'b0;
            end
         endcase
      end
   end

   // Control and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shifter   <= '0;
         bit_cnt   <= '0;
         ptr       <= '0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
      end else begin
         shifter   <= shifter_next;
         bit_cnt   <= bit_cnt_next;
         ptr       <= ptr_next;
         sda_oe    <= sda_oe_next;
         busy      <= busy_next;
         wr_strobe <= wr_strobe_next;
      end
   end

   // Register memory; cleared by reset, written when a data byte is ACKed.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < MemDepth; i++) begin
            mem[i] <= 8'h00;
         end
      end else if (mem_we) begin
         mem[ptr] <= shifter;
      end
   end

   assign sda_oe_o    = sda_oe;
   assign busy_o      = busy;
   assign ptr_o       = ptr;
   assign wr_strobe_o = wr_strobe;

endmodule

// File: tb/tb_i2c_target_mem.sv
// Directed bench for i2c_target_mem: a bit-banged I2C controller drives the
// bus, expected ACK bits and read bytes go through a scoreboard queue.
module tb_i2c_target_mem;

   localparam int Q = 10;  // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   logic       scl_bus, sda_bus;
   logic       sda_oe, busy, wr_strobe;
   logic [3:0] ptr;

   int checks = 0;
   int failures = 0;
   int strobes = 0;
   int oe_cnt = 0;
   int busy_cnt = 0;
   int viol = 0;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   always #5 clk = ~clk;

   assign scl_bus = scl_drv;
   assign sda_bus = sda_drv & ~sda_oe;

   i2c_target_mem #(.TargetAddr(7'h50), .MemDepth(16), .SyncStages(2)) dut (
      .clk_i(clk), .rst_i(rst), .scl_i(scl_bus), .sda_i(sda_bus),
      .sda_oe_o(sda_oe), .busy_o(busy), .ptr_o(ptr), .wr_strobe_o(wr_strobe)
   );

   // Count write strobes.
   always @(posedge clk) if (wr_strobe) strobes++;

   // Track SDA drive and busy, and any drive while not busy.
   always @(negedge clk) begin
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
      if (sda_oe && !busy) viol++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wq(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; wq(Q);
      scl_drv = 1'b1; wq(Q);
      sda_drv = 1'b0; wq(Q);
      scl_drv = 1'b0; wq(Q);
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; wq(Q);
      scl_drv = 1'b1; wq(Q);
      sda_drv = 1'b1; wq(Q);
   endtask

   task automatic bit_io(input logic b, output logic r);
      sda_drv = b;    wq(Q);
      scl_drv = 1'b1; wq(Q);
      r = sda_bus;    wq(Q);
      scl_drv = 1'b0; wq(Q);
   endtask

   task automatic write_byte(input string tag, input logic [7:0] d, input logic ack_exp);
      logic r;
      exp_q.push_back({7'd0, ack_exp});
      tag_q.push_back(tag);
      for (int i = 7; i >= 0; i--) bit_io(d[i], r);
      bit_io(1'b1, r);
      check(tag_q.pop_front(), 32'(r), 32'(exp_q.pop_front()));
   endtask

   task automatic read_byte(input string tag, input logic [7:0] exp, input logic ack_bit);
      logic       r;
      logic [7:0] b;
      b = '0;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      for (int i = 0; i < 8; i++) begin
         bit_io(1'b1, r);
         b = {b[6:0], r};
      end
      bit_io(ack_bit, r);
      check(tag_q.pop_front(), 32'(b), 32'(exp_q.pop_front()));
   endtask

   task automatic partial_bits(input logic [3:0] d);
      logic r;
      for (int i = 3; i >= 0; i--) bit_io(d[i], r);
   endtask

   initial begin
      int o0, b0;
      // Reset state
      wq(3);
      check("rst_oe", 32'(sda_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ptr", 32'(ptr), 32'd0);
      check("rst_strobe", 32'(wr_strobe), 32'd0);
      rst = 1'b0;
      wq(5);

      // Pointer write then two data bytes
      i2c_start();
      write_byte("t1_addr_ack", 8'hA0, 1'b0);
      check("t1_busy", 32'(busy), 32'd1);
      write_byte("t1_ptr_ack", 8'h03, 1'b0);
      write_byte("t1_d0_ack", 8'h11, 1'b0);
      write_byte("t1_d1_ack", 8'h22, 1'b0);
      i2c_stop();
      wq(5);
      check("t1_strobes", 32'(strobes), 32'd2);
      check("t1_ptr", 32'(ptr), 32'd5);
      check("t1_busy_after", 32'(busy), 32'd0);

      // Random read via repeated START
      i2c_start();
      write_byte("t2_addr_ack", 8'hA0, 1'b0);
      write_byte("t2_ptr_ack", 8'h03, 1'b0);
      check("t2_ptr_set", 32'(ptr), 32'd3);
      i2c_start();
      write_byte("t2_raddr_ack", 8'hA1, 1'b0);
      read_byte("t2_rd0", 8'h11, 1'b0);
      read_byte("t2_rd1", 8'h22, 1'b1);
      i2c_stop();
      wq(5);
      check("t2_ptr", 32'(ptr), 32'd5);
      check("t2_busy_after", 32'(busy), 32'd0);
      check("t2_strobes", 32'(strobes), 32'd2);

      // Address mismatch: never driven, never busy
      o0 = oe_cnt;
      b0 = busy_cnt;
      i2c_start();
      write_byte("t3_addr_nack", 8'hA2, 1'b1);
      write_byte("t3_d0_nack", 8'h5A, 1'b1);
      write_byte("t3_d1_nack", 8'h00, 1'b1);
      write_byte("t3_d2_nack", 8'hFF, 1'b1);
      i2c_stop();
      wq(5);
      check("t3_oe_cycles", 32'(oe_cnt - o0), 32'd0);
      check("t3_busy_cycles", 32'(busy_cnt - b0), 32'd0);
      check("t3_ptr", 32'(ptr), 32'd5);
      check("t3_strobes", 32'(strobes), 32'd2);

      // Pointer wrap on write and read
      i2c_start();
      write_byte("t4_addr_ack", 8'hA0, 1'b0);
      write_byte("t4_ptr_ack", 8'h0F, 1'b0);
      write_byte("t4_d0_ack", 8'hAA, 1'b0);
      write_byte("t4_d1_ack", 8'hBB, 1'b0);
      i2c_stop();
      wq(5);
      check("t4_strobes", 32'(strobes), 32'd4);
      check("t4_ptr_wr", 32'(ptr), 32'd1);
      i2c_start();
      write_byte("t4_addr2_ack", 8'hA0, 1'b0);
      write_byte("t4_ptr2_ack", 8'h0F, 1'b0);
      i2c_start();
      write_byte("t4_raddr_ack", 8'hA1, 1'b0);
      read_byte("t4_rd0", 8'hAA, 1'b0);
      read_byte("t4_rd1", 8'hBB, 1'b1);
      i2c_stop();
      wq(5);
      check("t4_ptr_rd", 32'(ptr), 32'd1);

      // STOP mid-byte discards the partial write
      i2c_start();
      write_byte("t5_addr_ack", 8'hA0, 1'b0);
      write_byte("t5_ptr_ack", 8'h03, 1'b0);
      partial_bits(4'b1010);
      i2c_stop();
      wq(5);
      check("t5_strobes", 32'(strobes), 32'd4);
      check("t5_ptr", 32'(ptr), 32'd3);
      i2c_start();
      write_byte("t5_addr2_ack", 8'hA0, 1'b0);
      write_byte("t5_ptr2_ack", 8'h03, 1'b0);
      i2c_start();
      write_byte("t5_raddr_ack", 8'hA1, 1'b0);
      read_byte("t5_rd0", 8'h11, 1'b0);
      read_byte("t5_rd1", 8'h22, 1'b1);
      i2c_stop();
      wq(5);
      check("t5_ptr_rd", 32'(ptr), 32'd5);
      check("t5_strobes_rd", 32'(strobes), 32'd4);

      // Reset while the target holds SDA low during a read
      i2c_start();
      write_byte("t6_addr_ack", 8'hA0, 1'b0);
      write_byte("t6_ptr_ack", 8'h03, 1'b0);
      i2c_start();
      write_byte("t6_raddr_ack", 8'hA1, 1'b0);
      check("t6_oe_driving", 32'(sda_oe), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_oe_after_rst", 32'(sda_oe), 32'd0);
      check("t6_ptr_after_rst", 32'(ptr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("t6_busy_after_rst", 32'(busy), 32'd0);
      i2c_stop();
      wq(5);
      i2c_start();
      write_byte("t6_raddr2_ack", 8'hA1, 1'b0);
      read_byte("t6_rd0", 8'h00, 1'b0);
      read_byte("t6_rd1", 8'h00, 1'b1);
      i2c_stop();
      wq(5);
      check("t6_ptr_rd", 32'(ptr), 32'd2);
      i2c_start();
      write_byte("t6_addr3_ack", 8'hA0, 1'b0);
      write_byte("t6_ptr3_ack", 8'h03, 1'b0);
      i2c_start();
      write_byte("t6_raddr3_ack", 8'hA1, 1'b0);
      read_byte("t6_rd_cleared", 8'h00, 1'b1);
      i2c_stop();
      wq(5);

      check("oe_without_busy", 32'(viol), 32'd0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
